// File: rtl/ddc_edid_responder.sv
// DDC/EDID I2C target: synchronises and deglitches SCL/SDA, then answers reads
// of an external EDID store through an auto-incrementing byte offset.
module ddc_edid_responder #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h50,
  parameter int         FILTER_LENGTH  = 4
) (
  input  logic       system_clock,
  input  logic       system_reset,
  input  logic       scl_input,
  input  logic       sda_input,
  output logic       sda_output,
  output logic [7:0] edid_address,
  input  logic [7:0] edid_data,
  output logic       busy,
  output logic       read_done
);

  localparam int CW = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH + 1) : 1;

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ADDRESS      = 3'd1;
  localparam logic [2:0] ADDRESS_ACK  = 3'd2;
  localparam logic [2:0] WRITE_OFFSET = 3'd3;
  localparam logic [2:0] WRITE_ACK    = 3'd4;
  localparam logic [2:0] READ_DATA    = 3'd5;
  localparam logic [2:0] READ_ACK     = 3'd6;
  localparam logic [2:0] IGNORE       = 3'd7;

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;
  assign raw_lines = {sda_input, scl_input};

  // Line 0 is SCL, line 1 is SDA; a level only changes after FILTER_LENGTH
  // consecutive disagreeing samples.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic          sync1_reg;
      logic          sync2_reg;
      logic          filt_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge system_clock) begin
        if (system_reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_lines[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(FILTER_LENGTH - 1)) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign filt_lines[gi] = filt_reg;
    end
  endgenerate

  logic scl_f, sda_f, scl_prev_reg, sda_prev_reg;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt_lines[0];
  assign sda_f     = filt_lines[1];
  assign scl_rise  = scl_f & ~scl_prev_reg;
  assign scl_fall  = ~scl_f & scl_prev_reg;
  assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  logic [2:0] state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg, tx_reg, offset_reg;
  logic       sda_out_reg, busy_reg, read_done_reg, offset_set_reg, ack_reg;

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      scl_prev_reg   <= 1'b1;
      sda_prev_reg   <= 1'b1;
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      tx_reg         <= '0;
      offset_reg     <= '0;
      sda_out_reg    <= 1'b1;
      busy_reg       <= 1'b0;
      read_done_reg  <= 1'b0;
      offset_set_reg <= 1'b0;
      ack_reg        <= 1'b1;
    end else begin
      scl_prev_reg  <= scl_f;
      sda_prev_reg  <= sda_f;
      read_done_reg <= 1'b0;
      // Bus conditions outrank any bit activity seen on the same cycle.
      if (start_det) begin
        state_reg   <= ADDRESS;
        bit_cnt_reg <= '0;
        sda_out_reg <= 1'b1;
        busy_reg    <= 1'b0;
      end else if (stop_det) begin
        state_reg   <= IDLE;
        sda_out_reg <= 1'b1;
        busy_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ADDRESS, WRITE_OFFSET: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_f};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && bit_cnt_reg == 4'd8) begin
              bit_cnt_reg <= '0;
              if (state_reg == WRITE_OFFSET) begin
                // Only the first written byte is an offset; later ones are dropped.
                if (!offset_set_reg) offset_reg <= shift_reg;
                offset_set_reg <= 1'b1;
                state_reg      <= WRITE_ACK;
                sda_out_reg    <= 1'b0;
              end else if (shift_reg[7:1] == DEVICE_ADDRESS) begin
                state_reg   <= ADDRESS_ACK;
                sda_out_reg <= 1'b0;
                busy_reg    <= 1'b1;
              end else begin
                state_reg <= IGNORE;
              end
            end
          end
          ADDRESS_ACK: begin
            if (scl_fall) begin
              if (shift_reg[0]) begin
                state_reg   <= READ_DATA;
                tx_reg      <= edid_data;
                sda_out_reg <= edid_data[7];
              end else begin
                state_reg      <= WRITE_OFFSET;
                offset_set_reg <= 1'b0;
                sda_out_reg    <= 1'b1;
              end
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              state_reg   <= WRITE_OFFSET;
              sda_out_reg <= 1'b1;
            end
          end
          READ_DATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                state_reg   <= READ_ACK;
                bit_cnt_reg <= '0;
                sda_out_reg <= 1'b1;
              end else begin
                sda_out_reg <= tx_reg[6];
                tx_reg      <= {tx_reg[6:0], 1'b1};
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              ack_reg       <= sda_f;
              read_done_reg <= 1'b1;
              offset_reg    <= offset_reg + 8'd1;
            end else if (scl_fall) begin
              if (!ack_reg) begin
                state_reg   <= READ_DATA;
                tx_reg      <= edid_data;
                sda_out_reg <= edid_data[7];
              end else begin
                state_reg <= IGNORE;
              end
            end
          end
          default: sda_out_reg <= 1'b1;
        endcase
      end
    end
  end

  assign sda_output   = sda_out_reg;
  assign edid_address = offset_reg;
  assign busy         = busy_reg;
  assign read_done    = read_done_reg;

endmodule

// File: doc/ddc_edid_responder.md
DDC_EDID_RESPONDER -- requirements
Module: ddc_edid_responder

Interface
REQ-001 SHALL have parameter DEVICE_ADDRESS, default 7'h50, the 7-bit I2C target address answered.
REQ-002 SHALL have parameter FILTER_LENGTH, default 4, the number of consecutive equal system_clock samples required before a filtered SCL/SDA level changes.
REQ-003 SHALL have port system_clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port system_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port scl_input, input, 1, raw SCL level from the pad buffer.
REQ-006 SHALL have port sda_input, input, 1, raw SDA level from the pad buffer.
REQ-007 SHALL have port sda_output, output, 1, open-drain drive: 0 = pull SDA low, 1 = release.
REQ-008 SHALL have port edid_address, output, 8, byte address into the external EDID store.
REQ-009 SHALL have port edid_data, input, 8, EDID byte at edid_address, valid one system_clock cycle after edid_address changes.
REQ-010 SHALL have port busy, output, 1, high from an addressed START until the next STOP or START.
REQ-011 SHALL have port read_done, output, 1, one-cycle pulse for each byte the initiator ACKs or NACKs on a read.

Function
REQ-012 SHALL pass scl_input and sda_input through a 2-flop synchronizer and then the FILTER_LENGTH glitch filter; all decoding SHALL use only the filtered levels.
REQ-013 SHALL detect START as filtered SDA falling while filtered SCL is high, and STOP as filtered SDA rising while filtered SCL is high.
REQ-014 SHALL sample SDA on filtered SCL rising edges and change sda_output only on the cycle after a filtered SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDRESS, ADDRESS_ACK, WRITE_OFFSET, WRITE_ACK, READ_DATA, READ_ACK, IGNORE.
REQ-016 SHALL go from any state to ADDRESS on START (repeated START included), with the bit counter cleared.
REQ-017 SHALL go from any state to IDLE on STOP, releasing SDA.
REQ-018 In ADDRESS, SHALL shift 8 bits MSB first; if bits[7:1] equal DEVICE_ADDRESS SHALL enter ADDRESS_ACK, otherwise IGNORE with SDA released.
REQ-019 In ADDRESS_ACK, SHALL drive SDA low for exactly one SCL period, then enter WRITE_OFFSET if R/W=0 or READ_DATA if R/W=1.
REQ-020 In WRITE_OFFSET, SHALL shift 8 bits, load the received byte into the offset pointer, and enter WRITE_ACK (ACK driven low).
REQ-021 After WRITE_ACK, further written bytes SHALL be ACKed and discarded, with the offset left unchanged.
REQ-022 In READ_DATA, SHALL drive edid_data bit 7 down to bit 0, latched at byte start, releasing SDA for 1-bits and pulling low for 0-bits.
REQ-023 In READ_ACK, SHALL release SDA, sample the initiator bit, pulse read_done, and increment the offset modulo 256 (0xFF wraps to 0x00).
REQ-024 After READ_ACK, SHALL return to READ_DATA on ACK (0) or enter IGNORE on NACK (1).
REQ-025 IGNORE SHALL keep SDA released until START or STOP.
REQ-026 edid_address SHALL always equal the offset pointer.
REQ-027 The offset pointer SHALL persist across transactions and be cleared only by reset.
REQ-028 START and STOP SHALL take priority over bit processing when they coincide with an SCL edge on the same cycle.

Reset
REQ-029 While system_reset is high, state SHALL be IDLE, sda_output=1, busy=0, read_done=0, offset=0x00, edid_address=0x00, and synchronizer/filter outputs=1.
REQ-030 Reset asserted mid-transfer SHALL release SDA on the next cycle; the block SHALL ignore the bus until a fresh START after reset deasserts.

Verification
REQ-031 Write 0xA0, 0x10, STOP -> both bytes ACKed, edid_address=0x10, busy low after STOP.
REQ-032 Write 0xA0, 0x7E, repeated START, 0xA1, read 3 bytes (ACK,ACK,NACK) -> data from 0x7E, 0x7F, 0x80; three read_done pulses; offset=0x81.
REQ-033 Address 0xA2 -> SDA never driven low, state IGNORE, busy=0.
REQ-034 Offset 0xFF, read 2 bytes -> bytes from 0xFF then 0x00.
REQ-035 1-cycle SDA glitch while SCL high, FILTER_LENGTH=4 -> no START/STOP detected, no state change.
REQ-036 system_reset pulsed while driving a 0 read bit -> sda_output=1 next cycle, offset=0x00, following transaction decoded normally.
